// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transmitter handshake bundle for uart_tx_scheduler
interface uart_tx_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   ack;
   logic               tx_wr;
   logic [7:0]         tx_data;
   logic               tx_busy;

   // slave: the scheduler itself
   modport slave (
      input  req, req_data, tx_busy,
      output ack, tx_wr, tx_data
   );

   // master: the surrounding producers and transmitter
   modport master (
      output req, req_data, tx_busy,
      input  ack, tx_wr, tx_data
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART transmitter between N_REQ byte producers
module uart_tx_scheduler #(
   parameter int         N_REQ        = 4,
   parameter int         BUSY_TIMEOUT = 64,
   parameter logic [2:0] BAUD_DEFAULT = 3'b111
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [2:0]             cfg_baud,
   output logic                   tx_en,
   output logic [2:0]             baud_select,
   output logic [2:0]             active_id,
   output logic                   timeout_err,
   uart_tx_scheduler_if.slave     bus
);
   localparam int             CW      = $clog2(BUSY_TIMEOUT);
   localparam logic [CW-1:0]  CNT_MAX = CW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               tx_wr_q, tx_wr_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_en_q, tx_en_d;
   logic [2:0]         baud_q, baud_d;
   logic [2:0]         active_id_q, active_id_d;
   logic               timeout_err_q, timeout_err_d;
   logic [2:0]         last_id_q, last_id_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               found;
   logic [2:0]         winner;
   logic [3:0]         cand;
   logic [8*N_REQ-1:0] data_sh;

   // Search starts just after the last winner, wrapping modulo N_REQ.
   always_comb begin
      found  = 1'b0;
      winner = 3'd0;
      cand   = 4'd0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = 4'(last_id_q) + 4'(off);
         if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
         if (!found && (|(bus.req & (N_REQ'(1) << cand)))) begin
            found  = 1'b1;
            winner = cand[2:0];
         end
      end
   end

   assign data_sh = bus.req_data >> {winner, 3'b000};

   always_comb begin
      state_d       = state_q;
      ack_d         = '0;
      tx_wr_d       = 1'b0;
      timeout_err_d = 1'b0;
      tx_data_d     = tx_data_q;
      baud_d        = baud_q;
      active_id_d   = active_id_q;
      last_id_d     = last_id_q;
      cnt_d         = cnt_q;
      tx_en_d       = enable | (state_q != IDLE);
      case (state_q)
         IDLE: begin
            baud_d = cfg_baud;
            if (enable && found) begin
               tx_data_d   = data_sh[7:0];
               active_id_d = winner;
               ack_d       = N_REQ'(1) << winner;
               last_id_d   = winner;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            tx_wr_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_MAX) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            // No timeout here: frame length scales with the selected baud.
            if (!bus.tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ack_q         <= '0;
         tx_wr_q       <= 1'b0;
         tx_data_q     <= 8'h00;
         tx_en_q       <= 1'b0;
         baud_q        <= BAUD_DEFAULT;
         active_id_q   <= 3'd0;
         timeout_err_q <= 1'b0;
         last_id_q     <= 3'(N_REQ - 1);
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         tx_wr_q       <= tx_wr_d;
         tx_data_q     <= tx_data_d;
         tx_en_q       <= tx_en_d;
         baud_q        <= baud_d;
         active_id_q   <= active_id_d;
         timeout_err_q <= timeout_err_d;
         last_id_q     <= last_id_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.tx_wr    = tx_wr_q;
   assign bus.tx_data  = tx_data_q;
   assign tx_en        = tx_en_q;
   assign baud_select  = baud_q;
   assign active_id    = active_id_q;
   assign timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] cfg_baud;
   logic       tx_en;
   logic [2:0] baud_select;
   logic [2:0] active_id;
   logic       timeout_err;

   uart_tx_scheduler_if #(.N_REQ(N)) bus ();

   uart_tx_scheduler #(.N_REQ(N), .BUSY_TIMEOUT(64), .BAUD_DEFAULT(3'b111)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .cfg_baud    (cfg_baud),
      .tx_en       (tx_en),
      .baud_select (baud_select),
      .active_id   (active_id),
      .timeout_err (timeout_err),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] id;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      int          busy;
      int          exp_id;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[8];

   int errors = 0, checks = 0;
   int cyc = 0, ack_cnt = 0, wr_cnt = 0, to_cnt = 0;
   int last_ack = 0, last_wr = 0, last_to = 0;
   int busy_cnt = 0, busy_len = 10;
   logic tie0 = 1'b0, pending = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ack_index(input logic [N-1:0] a);
      int r = -1;
      for (int i = 0; i < N; i++) if (a[i]) r = i;
      return r;
   endfunction

   task automatic push(input int id, input logic [31:0] data);
      exp_t e;
      e.id   = 8'(id);
      e.data = 8'(data >> (8 * id));
      sb.push_back(e);
   endtask

   // One clock: sample outputs at the falling edge, score them, then update the transmitter model.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
         ack_cnt++;
         chk("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: got ack=%b with empty scoreboard (cycle %0d)", bus.ack, cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_id", 32'(ack_index(bus.ack)), 32'(e.id));
            chk("tx_data", 32'(bus.tx_data), 32'(e.data));
         end
         chk("outstanding", {30'd0, pending, bus.tx_busy}, 32'd0);
         pending  = 1'b1;
         last_ack = cyc;
      end
      if (bus.tx_wr) begin
         wr_cnt++;
         chk("wr_latency", 32'(cyc - last_ack), 32'd1);
         pending = 1'b0;
         last_wr = cyc;
         if (!tie0) busy_cnt = busy_len;
      end
      if (timeout_err) begin
         to_cnt++;
         last_to = cyc;
      end
      bus.tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
   endtask

   task automatic wait_ack(input int budget);
      int start = ack_cnt;
      int n = 0;
      while (ack_cnt == start && n < budget) begin
         step();
         n++;
      end
      chk("ack_arrived", 32'(ack_cnt - start), 32'd1);
   endtask

   task automatic reset_dut();
      reset       = 1'b1;
      busy_cnt    = 0;
      bus.tx_busy = 1'b0;
      pending     = 1'b0;
      bus.req     = '0;
      repeat (2) step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int a0, w0, n;
      tbl[0] = '{4'b0001, 32'h3C965AA5, 20, 0};
      tbl[1] = '{4'b0110, 32'h44332211, 3,  1};
      tbl[2] = '{4'b0110, 32'h44332211, 3,  2};
      tbl[3] = '{4'b0110, 32'hDEADBEEF, 3,  1};
      tbl[4] = '{4'b1001, 32'h807F0102, 3,  3};
      tbl[5] = '{4'b1001, 32'h807F0102, 3,  0};
      tbl[6] = '{4'b1000, 32'hC3000000, 3,  3};
      tbl[7] = '{4'b1111, 32'h0F1E2D3C, 3,  0};

      reset        = 1'b1;
      enable       = 1'b1;
      cfg_baud     = 3'b111;
      bus.req      = '0;
      bus.req_data = '0;
      bus.tx_busy  = 1'b0;
      #1;
      chk("reset_outputs",
          {19'd0, bus.ack, bus.tx_wr, bus.tx_data},
          {19'd0, 4'b0000, 1'b0, 8'h00});
      chk("reset_misc", {24'd0, tx_en, baud_select, active_id, timeout_err},
          {24'd0, 1'b0, 3'b111, 3'b000, 1'b0});
      reset_dut();

      // Round-robin vector table, applied back to back without reset.
      for (int i = 0; i < 8; i++) begin
         bus.req_data = tbl[i].data;
         busy_len     = tbl[i].busy;
         push(tbl[i].exp_id, tbl[i].data);
         a0 = ack_cnt;
         w0 = wr_cnt;
         bus.req = tbl[i].req;
         wait_ack(20);
         bus.req = '0;
         chk("active_id", 32'(active_id), 32'(tbl[i].exp_id));
         repeat (tbl[i].busy + 8) step();
         chk("ack_pulses", 32'(ack_cnt - a0), 32'd1);
         chk("wr_pulses", 32'(wr_cnt - w0), 32'd1);
         chk("tx_en_on", 32'(tx_en), 32'd1);
      end

      // All requesters held: strict rotation from requester 0.
      reset_dut();
      busy_len     = 10;
      bus.req_data = 32'h44332211;
      push(0, bus.req_data); push(1, bus.req_data); push(2, bus.req_data);
      push(3, bus.req_data); push(0, bus.req_data);
      a0 = ack_cnt;
      w0 = wr_cnt;
      bus.req = 4'b1111;
      n = 0;
      while (ack_cnt - a0 < 5 && n < 400) begin
         step();
         n++;
      end
      bus.req = '0;
      repeat (20) step();
      chk("rr_acks", 32'(ack_cnt - a0), 32'd5);
      chk("rr_wrs", 32'(wr_cnt - w0), 32'd5);

      // tx_busy never rises: timeout after 64 cycles, then service resumes.
      reset_dut();
      tie0         = 1'b1;
      bus.req_data = 32'h55667788;
      push(0, bus.req_data);
      bus.req = 4'b0001;
      wait_ack(10);
      bus.req = '0;
      a0 = to_cnt;
      n  = 0;
      while (to_cnt == a0 && n < 200) begin
         step();
         n++;
      end
      chk("timeout_seen", 32'(to_cnt - a0), 32'd1);
      chk("timeout_latency", 32'(last_to - last_wr), 32'd64);
      step();
      chk("timeout_width", 32'(timeout_err), 32'd0);
      push(1, bus.req_data);
      bus.req = 4'b0010;
      wait_ack(10);
      bus.req = '0;
      repeat (80) step();
      tie0 = 1'b0;

      // Baud request changing mid-frame is deferred to IDLE.
      reset_dut();
      busy_len = 20;
      cfg_baud = 3'b111;
      bus.req_data = 32'h000000C5;
      push(0, bus.req_data);
      bus.req = 4'b0001;
      wait_ack(10);
      bus.req = '0;
      repeat (4) step();
      cfg_baud = 3'b010;
      repeat (5) step();
      chk("baud_held", 32'(baud_select), 32'b111);
      repeat (20) step();
      chk("baud_updated", 32'(baud_select), 32'b010);
      cfg_baud = 3'b111;

      // enable dropped mid-transfer: byte completes, no new grant until re-enabled.
      reset_dut();
      busy_len     = 10;
      bus.req_data = 32'h0BADF00D;
      push(0, bus.req_data);
      w0 = wr_cnt;
      bus.req = 4'b0001;
      wait_ack(10);
      step();
      enable  = 1'b0;
      bus.req = 4'b0110;
      a0 = ack_cnt;
      repeat (30) step();
      chk("no_ack_disabled", 32'(ack_cnt - a0), 32'd0);
      chk("byte_completed", 32'(wr_cnt - w0), 32'd1);
      chk("tx_en_off", 32'(tx_en), 32'd0);
      push(1, bus.req_data);
      enable = 1'b1;
      wait_ack(10);
      bus.req = '0;
      repeat (20) step();

      // Reset in WAIT_DONE: outputs return to reset values immediately.
      reset_dut();
      busy_len     = 20;
      cfg_baud     = 3'b001;
      bus.req_data = 32'h11223344;
      push(2, bus.req_data);
      bus.req = 4'b0100;
      wait_ack(10);
      bus.req = '0;
      repeat (5) step();
      #2;
      reset = 1'b1;
      #1;
      chk("midframe_reset_bus", {19'd0, bus.ack, bus.tx_wr, bus.tx_data},
          {19'd0, 4'b0000, 1'b0, 8'h00});
      chk("midframe_reset_misc", {24'd0, tx_en, baud_select, active_id, timeout_err},
          {24'd0, 1'b0, 3'b111, 3'b000, 1'b0});
      busy_cnt    = 0;
      bus.tx_busy = 1'b0;
      pending     = 1'b0;
      repeat (2) step();
      reset    = 1'b0;
      cfg_baud = 3'b111;
      step();
      push(0, bus.req_data);
      bus.req = 4'b0101;
      wait_ack(10);
      bus.req = '0;
      repeat (30) step();

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
